// File: rtl/dtm_dmi_pkg.sv
// Shared types and constants for the JTAG debug transport module:
// TAP states, DMI op/status codes, DMI FSM states and instruction codes.
package dtm_dmi_pkg;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0,
    RUN_TEST_IDLE    = 4'h1,
    SELECT_DR_SCAN   = 4'h2,
    CAPTURE_DR       = 4'h3,
    SHIFT_DR         = 4'h4,
    EXIT1_DR         = 4'h5,
    PAUSE_DR         = 4'h6,
    EXIT2_DR         = 4'h7,
    UPDATE_DR        = 4'h8,
    SELECT_IR_SCAN   = 4'h9,
    CAPTURE_IR       = 4'ha,
    SHIFT_IR         = 4'hb,
    EXIT1_IR         = 4'hc,
    PAUSE_IR         = 4'hd,
    EXIT2_IR         = 4'he,
    UPDATE_IR        = 4'hf
  } tap_states_e;

  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2,
    DMI_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    STAT_OK     = 2'd0,
    STAT_RSVD   = 2'd1,
    STAT_FAILED = 2'd2,
    STAT_BUSY   = 2'd3
  } dmi_stat_e;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_REQ  = 2'd1,
    FSM_WAIT = 2'd2
  } dmi_fsm_e;

  // Instruction codes; truncated to IR_LEN where they are compared.
  localparam logic [7:0] INSN_IDCODE = 8'h01;
  localparam logic [7:0] INSN_DTMCS  = 8'h10;
  localparam logic [7:0] INSN_DMI    = 8'h11;
  localparam logic [7:0] INSN_BYPASS = 8'hff;

  // Any non-zero response code (including the reserved ones) is a failure.
  function automatic logic rsp_failed(input logic [1:0] op);
    return op != 2'd0;
  endfunction

endpackage

// File: rtl/dtm_dmi_if.sv
// DMI request/response handshake between the DTM (master) and the Debug Module (slave).
interface dtm_dmi_if #(parameter int ABITS = 7) ();
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [ABITS-1:0] req_addr;
  logic [31:0]      req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_op;
  logic [31:0]      rsp_data;

  modport master (
    output req_valid, req_op, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_op, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_op, rsp_data
  );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with instruction register; exposes state strobes
// and the active instruction to the data-register logic.
module jtag_tap_ctrl
  import dtm_dmi_pkg::*;
#(
  parameter int IR_LEN = 5
) (
  input  logic              tck_i,
  input  logic              trstn_i,
  input  logic              tms_i,
  input  logic              tdi_i,
  output logic              tlr_s,
  output logic              capture_dr_s,
  output logic              shift_dr_s,
  output logic              update_dr_s,
  output logic              capture_ir_s,
  output logic              shift_ir_s,
  output logic              update_ir_s,
  output logic [IR_LEN-1:0] ir_s,
  output logic              ir_tdo_s
);

  tap_states_e       state_r, state_n_s;
  logic [IR_LEN-1:0] ir_shift_r, ir_r;

  // TAP state register
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) state_r <= TEST_LOGIC_RESET;
    else          state_r <= state_n_s;
  end

  // TAP next-state decode from TMS
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      TEST_LOGIC_RESET: state_n_s = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    state_n_s = tms_i ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_DR_SCAN:   state_n_s = tms_i ? SELECT_IR_SCAN   : CAPTURE_DR;
      CAPTURE_DR:       state_n_s = tms_i ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         state_n_s = tms_i ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         state_n_s = tms_i ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         state_n_s = tms_i ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         state_n_s = tms_i ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        state_n_s = tms_i ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      SELECT_IR_SCAN:   state_n_s = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       state_n_s = tms_i ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         state_n_s = tms_i ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         state_n_s = tms_i ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         state_n_s = tms_i ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         state_n_s = tms_i ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        state_n_s = tms_i ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
      default:          state_n_s = TEST_LOGIC_RESET;
    endcase
  end

  assign tlr_s        = (state_r == TEST_LOGIC_RESET);
  assign capture_dr_s = (state_r == CAPTURE_DR);
  assign shift_dr_s   = (state_r == SHIFT_DR);
  assign update_dr_s  = (state_r == UPDATE_DR);
  assign capture_ir_s = (state_r == CAPTURE_IR);
  assign shift_ir_s   = (state_r == SHIFT_IR);
  assign update_ir_s  = (state_r == UPDATE_IR);
  assign ir_s         = ir_r;
  assign ir_tdo_s     = ir_shift_r[0];

  // IR shift chain and active instruction; reset selects IDCODE
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      ir_shift_r <= {IR_LEN{1'b0}};
      ir_r       <= IR_LEN'(INSN_IDCODE);
    end else if (tlr_s) begin
      ir_shift_r <= {IR_LEN{1'b0}};
      ir_r       <= IR_LEN'(INSN_IDCODE);
    end else begin
      if (capture_ir_s)    ir_shift_r <= {{(IR_LEN-2){1'b0}}, 2'b01};
      else if (shift_ir_s) ir_shift_r <= {tdi_i, ir_shift_r[IR_LEN-1:1]};
      if (update_ir_s)     ir_r <= ir_shift_r;
    end
  end

endmodule

// File: rtl/dtm_dmi.sv
// JTAG Debug Transport Module: IDCODE/DTMCS/DMI/BYPASS data registers and a
// single-outstanding DMI request/response engine, all in the TCK domain.
module dtm_dmi
  import dtm_dmi_pkg::*;
#(
  parameter int          ABITS      = 7,
  parameter int          IR_LEN     = 5,
  parameter logic [31:0] IDCODE_VAL = 32'h10e31913,
  parameter int          IDLE_HINT  = 1
) (
  input  logic       tck_i,
  input  logic       trstn_i,
  input  logic       tms_i,
  input  logic       tdi_i,
  output logic       tdo_o,
  dtm_dmi_if.master  dmi
);

  localparam int DMI_W = ABITS + 34;

  logic              tlr_s, capture_dr_s, shift_dr_s, update_dr_s;
  logic              capture_ir_s, shift_ir_s, update_ir_s, ir_tdo_s;
  logic [IR_LEN-1:0] ir_s;
  logic              sel_idcode_s, sel_dtmcs_s, sel_dmi_s, sel_bypass_s, dr_tdo_s;
  logic [31:0]       idcode_sr_r, dtmcs_sr_r, dtmcs_cap_s, rdata_r;
  logic              bypass_sr_r, tdo_r;
  logic [DMI_W-1:0]  dmi_sr_r;
  logic [1:0]        dmistat_r, req_op_r;
  logic [ABITS-1:0]  req_addr_r;
  logic [31:0]       req_data_r;
  logic              req_valid_r, rsp_ready_r;
  logic              dmireset_s, hardreset_s, dmi_capture_s, dmi_update_s;
  logic              busy_s, req_accept_s, rsp_done_s;
  dmi_fsm_e          fsm_r, fsm_n_s;

  jtag_tap_ctrl #(.IR_LEN(IR_LEN)) u_tap (
    .tck_i(tck_i), .trstn_i(trstn_i), .tms_i(tms_i), .tdi_i(tdi_i),
    .tlr_s(tlr_s), .capture_dr_s(capture_dr_s), .shift_dr_s(shift_dr_s),
    .update_dr_s(update_dr_s), .capture_ir_s(capture_ir_s), .shift_ir_s(shift_ir_s),
    .update_ir_s(update_ir_s), .ir_s(ir_s), .ir_tdo_s(ir_tdo_s)
  );

  // Instruction decode; unknown codes fall back to BYPASS
  always_comb begin
    sel_idcode_s = 1'b0;
    sel_dtmcs_s  = 1'b0;
    sel_dmi_s    = 1'b0;
    sel_bypass_s = 1'b0;
    if (ir_s == IR_LEN'(INSN_IDCODE))      sel_idcode_s = 1'b1;
    else if (ir_s == IR_LEN'(INSN_DTMCS))  sel_dtmcs_s  = 1'b1;
    else if (ir_s == IR_LEN'(INSN_DMI))    sel_dmi_s    = 1'b1;
    else if (ir_s == IR_LEN'(INSN_BYPASS)) sel_bypass_s = 1'b1;
    else                                   sel_bypass_s = 1'b1;
  end

  assign dtmcs_cap_s   = {14'd0, 1'b0, 1'b0, 1'b0, 3'(IDLE_HINT), dmistat_r, 6'(ABITS), 4'd1};
  assign dmireset_s    = update_dr_s & sel_dtmcs_s & dtmcs_sr_r[16];
  assign hardreset_s   = update_dr_s & sel_dtmcs_s & dtmcs_sr_r[17];
  assign dmi_capture_s = capture_dr_s & sel_dmi_s;
  assign dmi_update_s  = update_dr_s & sel_dmi_s;
  assign busy_s        = (fsm_r != FSM_IDLE);
  assign req_accept_s  = dmi_update_s & ~busy_s & (dmistat_r == STAT_OK) &
                         ((dmi_sr_r[1:0] == DMI_READ) || (dmi_sr_r[1:0] == DMI_WRITE));
  // A hardreset in the response cycle discards the response entirely.
  assign rsp_done_s    = (fsm_r == FSM_WAIT) & dmi.rsp_valid & ~hardreset_s;

  // Data-register capture and shift chains
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      idcode_sr_r <= 32'd0;
      bypass_sr_r <= 1'b0;
      dtmcs_sr_r  <= 32'd0;
      dmi_sr_r    <= {DMI_W{1'b0}};
    end else if (tlr_s) begin
      idcode_sr_r <= 32'd0;
      bypass_sr_r <= 1'b0;
      dtmcs_sr_r  <= 32'd0;
      dmi_sr_r    <= {DMI_W{1'b0}};
    end else if (capture_dr_s) begin
      if (sel_idcode_s)     idcode_sr_r <= IDCODE_VAL;
      else if (sel_dtmcs_s) dtmcs_sr_r  <= dtmcs_cap_s;
      else if (sel_dmi_s)   dmi_sr_r    <= busy_s ? {dmi_sr_r[DMI_W-1:2], 2'b11}
                                                  : {dmi_sr_r[DMI_W-1:34], rdata_r, dmistat_r};
      else                  bypass_sr_r <= 1'b0;
    end else if (shift_dr_s) begin
      if (sel_idcode_s)     idcode_sr_r <= {tdi_i, idcode_sr_r[31:1]};
      else if (sel_dtmcs_s) dtmcs_sr_r  <= {tdi_i, dtmcs_sr_r[31:1]};
      else if (sel_dmi_s)   dmi_sr_r    <= {tdi_i, dmi_sr_r[DMI_W-1:1]};
      else                  bypass_sr_r <= tdi_i;
    end
  end

  // Serial-out selection for the active data register
  always_comb begin
    dr_tdo_s = bypass_sr_r;
    if (sel_idcode_s)     dr_tdo_s = idcode_sr_r[0];
    else if (sel_dtmcs_s) dr_tdo_s = dtmcs_sr_r[0];
    else if (sel_dmi_s)   dr_tdo_s = dmi_sr_r[0];
    else                  dr_tdo_s = bypass_sr_r;
  end

  // TDO launched on the falling edge, held outside the shift states
  always_ff @(negedge tck_i or negedge trstn_i) begin
    if (!trstn_i)        tdo_r <= 1'b0;
    else if (shift_ir_s) tdo_r <= ir_tdo_s;
    else if (shift_dr_s) tdo_r <= dr_tdo_s;
    else                 tdo_r <= tdo_r;
  end

  // DMI FSM state register
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i)   fsm_r <= FSM_IDLE;
    else if (tlr_s) fsm_r <= FSM_IDLE;
    else            fsm_r <= fsm_n_s;
  end

  // DMI FSM next state; hardreset overrides any handshake in flight
  always_comb begin
    fsm_n_s = fsm_r;
    if (hardreset_s) begin
      fsm_n_s = FSM_IDLE;
    end else begin
      case (fsm_r)
        FSM_IDLE: fsm_n_s = req_accept_s ? FSM_REQ : FSM_IDLE;
        FSM_REQ:  fsm_n_s = (req_valid_r && dmi.req_ready) ? FSM_WAIT : FSM_REQ;
        FSM_WAIT: fsm_n_s = dmi.rsp_valid ? FSM_IDLE : FSM_WAIT;
        default:  fsm_n_s = FSM_IDLE;
      endcase
    end
  end

  // Registered handshake outputs, request fields and read-data capture
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      req_valid_r <= 1'b0;
      rsp_ready_r <= 1'b0;
      req_op_r    <= 2'd0;
      req_addr_r  <= {ABITS{1'b0}};
      req_data_r  <= 32'd0;
      rdata_r     <= 32'd0;
    end else if (tlr_s) begin
      req_valid_r <= 1'b0;
      rsp_ready_r <= 1'b0;
      req_op_r    <= 2'd0;
      req_addr_r  <= {ABITS{1'b0}};
      req_data_r  <= 32'd0;
      rdata_r     <= 32'd0;
    end else begin
      req_valid_r <= (fsm_n_s == FSM_REQ);
      rsp_ready_r <= (fsm_n_s == FSM_WAIT);
      if (req_accept_s) begin
        req_op_r   <= dmi_sr_r[1:0];
        req_data_r <= dmi_sr_r[33:2];
        req_addr_r <= dmi_sr_r[DMI_W-1:34];
      end
      if (rsp_done_s && (req_op_r == DMI_READ)) rdata_r <= dmi.rsp_data;
    end
  end

  // Sticky status: only the first non-zero code is kept until cleared
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i)                                     dmistat_r <= STAT_OK;
    else if (tlr_s)                                   dmistat_r <= STAT_OK;
    else if (dmireset_s || hardreset_s)               dmistat_r <= STAT_OK;
    else if (dmistat_r != STAT_OK)                    dmistat_r <= dmistat_r;
    else if ((dmi_capture_s || dmi_update_s) && busy_s) dmistat_r <= STAT_BUSY;
    else if (rsp_done_s && rsp_failed(dmi.rsp_op))    dmistat_r <= STAT_FAILED;
    else                                              dmistat_r <= dmistat_r;
  end

  assign tdo_o         = tdo_r;
  assign dmi.req_valid = req_valid_r;
  assign dmi.req_op    = req_op_r;
  assign dmi.req_addr  = req_addr_r;
  assign dmi.req_data  = req_data_r;
  assign dmi.rsp_ready = rsp_ready_r;

endmodule

// File: tb/tb_dtm_dmi.sv
// Directed bench for dtm_dmi: table of register scans plus hand-written DMI
// handshake sequences (stall, read, busy overlap, failure, hardreset).
module tb_dtm_dmi;

  logic tck = 1'b0;
  logic trstn, tms, tdi, tdo;
  int   total = 0;
  int   bad   = 0;

  dtm_dmi_if #(.ABITS(7)) dmi ();

  dtm_dmi #(.ABITS(7), .IR_LEN(5), .IDCODE_VAL(32'h10e31913), .IDLE_HINT(1)) dut (
    .tck_i(tck), .trstn_i(trstn), .tms_i(tms), .tdi_i(tdi), .tdo_o(tdo), .dmi(dmi)
  );

  always #5 tck = ~tck;

  typedef struct {
    string       name;
    logic [4:0]  ir;
    int          n;
    logic [63:0] din;
    logic [63:0] exp;
  } vec_t;

  vec_t tab[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One TCK: sample tdo after the falling edge, then drive TMS/TDI for the rising edge.
  task automatic step(input logic t, input logic d, output logic o);
    @(negedge tck);
    #2;
    o   = tdo;
    tms = t;
    tdi = d;
    @(posedge tck);
    #1;
  endtask

  task automatic idle(input int n);
    logic x;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, x);
  endtask

  // From RUN_TEST_IDLE through an IR scan back to RUN_TEST_IDLE.
  task automatic ir_scan(input logic [4:0] code, output logic [4:0] out);
    logic x;
    out = 5'd0;
    step(1'b1, 1'b0, x);
    step(1'b1, 1'b0, x);
    step(1'b0, 1'b0, x);
    step(1'b0, 1'b0, x);
    for (int i = 0; i < 5; i++) step(i == 4, code[i], out[i]);
    step(1'b1, 1'b0, x);
    step(1'b0, 1'b0, x);
  endtask

  // From RUN_TEST_IDLE through a DR scan of n bits back to RUN_TEST_IDLE.
  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout);
    logic x;
    dout = 64'd0;
    step(1'b1, 1'b0, x);
    step(1'b0, 1'b0, x);
    step(1'b0, 1'b0, x);
    for (int i = 0; i < n; i++) step(i == n - 1, din[i], dout[i]);
    step(1'b1, 1'b0, x);
    step(1'b0, 1'b0, x);
  endtask

  initial begin
    logic [4:0]  iro;
    logic [63:0] o;

    tab[0] = '{"idcode",      5'h01, 32, 64'h0,  64'h10e31913};
    tab[1] = '{"bypass_1f",   5'h1f, 5,  64'h0b, 64'h16};
    tab[2] = '{"bypass_00",   5'h00, 5,  64'h0b, 64'h16};
    tab[3] = '{"bypass_0a",   5'h0a, 5,  64'h06, 64'h0c};
    tab[4] = '{"dtmcs_idle",  5'h10, 32, 64'h0,  64'h1071};
    tab[5] = '{"idcode_tail", 5'h01, 34, 64'h1,  64'h1_10e31913};

    trstn = 1'b0; tms = 1'b1; tdi = 1'b0;
    dmi.req_ready = 1'b0; dmi.rsp_valid = 1'b0; dmi.rsp_op = 2'd0; dmi.rsp_data = 32'd0;
    #22;
    check("rst_tdo", {63'd0, tdo}, 64'd0);
    check("rst_req", {dmi.req_valid, dmi.rsp_ready, dmi.req_op, dmi.req_addr, dmi.req_data}, 64'd0);
    trstn = 1'b1;
    idle(1);

    // IDCODE is selected straight out of reset
    dr_scan(32, 64'h0, o);
    check("idcode_after_reset", o, 64'h10e31913);

    for (int i = 0; i < 6; i++) begin
      ir_scan(tab[i].ir, iro);
      check({tab[i].name, "_ircap"}, {59'd0, iro}, 64'h01);
      dr_scan(tab[i].n, tab[i].din, o);
      check(tab[i].name, o, tab[i].exp);
    end

    // Five TMS=1 clocks reach TEST_LOGIC_RESET and reselect IDCODE
    ir_scan(5'h10, iro);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, iro[0]);
    idle(1);
    dr_scan(32, 64'h0, o);
    check("tms_reset_idcode", o, 64'h10e31913);

    // Write with a 3-cycle ready stall
    ir_scan(5'h11, iro);
    dr_scan(41, {7'h10, 32'hdeadbeef, 2'd2}, o);
    check("dmi_first_capture", o, 64'd0);
    for (int k = 0; k < 4; k++) begin
      check("stall_valid", {63'd0, dmi.req_valid}, 64'd1);
      check("stall_fields", {dmi.req_addr, dmi.req_data, dmi.req_op}, {7'h10, 32'hdeadbeef, 2'd2});
      if (k == 3) dmi.req_ready = 1'b1;
      idle(1);
    end
    dmi.req_ready = 1'b0;
    check("wait_handshake", {62'd0, dmi.req_valid, dmi.rsp_ready}, 64'd1);
    dmi.rsp_valid = 1'b1; dmi.rsp_op = 2'd0; dmi.rsp_data = 32'hcafef00d;
    idle(1);
    dmi.rsp_valid = 1'b0;
    check("write_done_rsp_ready", {63'd0, dmi.rsp_ready}, 64'd0);
    dr_scan(41, {7'h10, 32'h0, 2'd0}, o);
    check("write_status", o, {7'h10, 32'h0, 2'd0});
    check("nop_no_request", {63'd0, dmi.req_valid}, 64'd0);

    // Read returning data
    dr_scan(41, {7'h04, 32'h0, 2'd1}, o);
    check("read_req_fields", {dmi.req_valid, dmi.req_addr, dmi.req_data, dmi.req_op},
          {1'b1, 7'h04, 32'h0, 2'd1});
    dmi.req_ready = 1'b1;
    idle(1);
    dmi.req_ready = 1'b0;
    dmi.rsp_valid = 1'b1; dmi.rsp_op = 2'd0; dmi.rsp_data = 32'h12345678;
    idle(1);
    dmi.rsp_valid = 1'b0;
    dr_scan(41, {7'h04, 32'h0, 2'd0}, o);
    check("read_data", o, {7'h04, 32'h12345678, 2'd0});

    // Busy overlap: capture and update while waiting for the response
    dr_scan(41, {7'h08, 32'ha5a5a5a5, 2'd2}, o);
    dmi.req_ready = 1'b1;
    idle(1);
    dmi.req_ready = 1'b0;
    dr_scan(41, {7'h09, 32'h11111111, 2'd1}, o);
    check("busy_capture", o, {7'h08, 32'ha5a5a5a5, 2'd3});
    check("busy_no_request", {62'd0, dmi.req_valid, dmi.rsp_ready}, 64'd1);
    dmi.rsp_valid = 1'b1; dmi.rsp_op = 2'd0; dmi.rsp_data = 32'h0;
    idle(1);
    dmi.rsp_valid = 1'b0;
    dr_scan(41, {7'h09, 32'h0, 2'd0}, o);
    check("busy_sticky", o, {7'h09, 32'h12345678, 2'd3});
    ir_scan(5'h10, iro);
    dr_scan(32, 64'h1_0000, o);
    check("dtmcs_busy", o, 64'h1c71);
    dr_scan(32, 64'h0, o);
    check("dmireset_cleared", o, 64'h1071);

    // Failed response is sticky and blocks later writes
    ir_scan(5'h11, iro);
    dr_scan(41, {7'h0c, 32'h0badf00d, 2'd2}, o);
    check("fail_pre_capture", o, {7'h09, 32'h12345678, 2'd0});
    dmi.req_ready = 1'b1;
    idle(1);
    dmi.req_ready = 1'b0;
    dmi.rsp_valid = 1'b1; dmi.rsp_op = 2'd2;
    idle(1);
    dmi.rsp_valid = 1'b0; dmi.rsp_op = 2'd0;
    dr_scan(41, {7'h0d, 32'h1, 2'd2}, o);
    check("fail_capture", o, {7'h0c, 32'h12345678, 2'd2});
    idle(2);
    check("fail_write_ignored", {63'd0, dmi.req_valid}, 64'd0);
    ir_scan(5'h10, iro);
    dr_scan(32, 64'h0, o);
    check("dtmcs_failed", o, 64'h1871);
    dr_scan(32, 64'h2_0000, o);
    dr_scan(32, 64'h0, o);
    check("hardreset_clears_stat", o, 64'h1071);

    // Hardreset while a request is outstanding
    ir_scan(5'h11, iro);
    dr_scan(41, {7'h11, 32'h55, 2'd2}, o);
    check("hr_pre_capture", o, {7'h0d, 32'h12345678, 2'd0});
    ir_scan(5'h10, iro);
    check("hr_valid_before", {63'd0, dmi.req_valid}, 64'd1);
    dr_scan(32, 64'h2_0000, o);
    check("hr_valid_dropped", {62'd0, dmi.req_valid, dmi.rsp_ready}, 64'd0);
    dmi.req_ready = 1'b1;
    idle(1);
    dmi.req_ready = 1'b0;
    check("hr_no_wait", {62'd0, dmi.req_valid, dmi.rsp_ready}, 64'd0);
    ir_scan(5'h11, iro);
    dr_scan(41, {7'h11, 32'h0, 2'd0}, o);
    check("hr_fsm_idle", o, {7'h11, 32'h12345678, 2'd0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
